br_stack: RTL and testbench

// - R10K-style branch checkpoint stack between Dispatch, ROB/RS, Map Table and Free List.
// - Each dispatched branch gets one checkpoint slot (one mask bit) holding a Map Table copy and a Free List head.
// - On resolution, broadcasts the branch bit; on mispredict, returns the recovery state and squashes younger slots.

---
 rtl/br_stack.sv | 121 ++++++++++++
 tb/tb_br_stack.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/br_stack.sv
// Branch checkpoint stack: one slot per in-flight branch, holding a map table copy
// and free-list head; resolves branches by dependency mask and supplies recovery state.
module br_stack #(
  parameter int BR_MASK_W  = 5,
  parameter int BR_STATE_W = 2,
  parameter int MT_NUM     = 32,
  parameter int PRF_IDX_W  = 6,
  parameter int FL_HEAD_W  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              is_br_i,
  input  logic                              is_cond_i,
  input  logic                              is_taken_i,
  input  logic [BR_STATE_W-1:0]             br_state_i,
  input  logic [BR_MASK_W-1:0]              br_dep_mask_i,
  input  logic [MT_NUM*(PRF_IDX_W+1)-1:0]   bak_mp_next_data_i,
  input  logic [FL_HEAD_W-1:0]              bak_fl_head_i,
  input  logic                              cdb_vld_i,
  input  logic [PRF_IDX_W-1:0]              cdb_tag_i,
  output logic [BR_MASK_W-1:0]              br_mask_o,
  output logic [BR_MASK_W-1:0]              br_bit_o,
  output logic                              full_o,
  output logic [MT_NUM*(PRF_IDX_W+1)-1:0]   rc_mt_all_data_o,
  output logic [FL_HEAD_W-1:0]              rc_fl_head_o
);

  localparam int ENT_W = PRF_IDX_W + 1;
  localparam int MT_W  = MT_NUM * ENT_W;
  localparam logic [BR_STATE_W-1:0] BR_NONE    = BR_STATE_W'(0);
  localparam logic [BR_STATE_W-1:0] BR_WRONG   = BR_STATE_W'(1);
  localparam logic [BR_STATE_W-1:0] BR_CORRECT = BR_STATE_W'(2);

  // Sets the ready bit of every map entry whose tag matches the CDB broadcast.
  function automatic logic [MT_W-1:0] cdb_wakeup(input logic [MT_W-1:0] d,
                                                 input logic vld,
                                                 input logic [PRF_IDX_W-1:0] tag);
    logic [MT_W-1:0] o;
    o = d;
    for (int j = 0; j < MT_NUM; j++)
      if (vld && d[j*ENT_W +: PRF_IDX_W] == tag) o[j*ENT_W + PRF_IDX_W] = 1'b1;
    return o;
  endfunction

  logic [BR_MASK_W-1:0] br_mask;
  logic [BR_MASK_W-1:0] dep_mask [BR_MASK_W];
  logic [MT_W-1:0]      mt       [BR_MASK_W];
  logic [FL_HEAD_W-1:0] fl_head  [BR_MASK_W];

  logic [BR_MASK_W-1:0] r_oh, alloc_oh, freed, dep_new, mask_nxt;
  logic                 hit, alloc_found, do_alloc, is_wrong, is_correct;
  logic [MT_W-1:0]      rc_mt_sel;
  logic [FL_HEAD_W-1:0] rc_fl_sel;
  logic                 unused_info;

  assign unused_info = ^{is_cond_i, is_taken_i};
  assign full_o      = &br_mask;
  assign br_mask_o   = br_mask;

  always_comb begin
    r_oh        = '0;
    hit         = 1'b0;
    alloc_oh    = '0;
    alloc_found = 1'b0;
    for (int k = 0; k < BR_MASK_W; k++) begin
      if (!hit && br_mask[k] && dep_mask[k] == br_dep_mask_i) begin
        r_oh[k] = 1'b1;
        hit     = 1'b1;
      end
      if (!alloc_found && !br_mask[k]) begin
        alloc_oh[k] = 1'b1;
        alloc_found = 1'b1;
      end
    end
    is_wrong   = hit && (br_state_i == BR_WRONG);
    is_correct = hit && (br_state_i == BR_CORRECT);
    // A mispredict in flight makes any same-cycle dispatch wrong-path, so it is dropped.
    do_alloc   = is_br_i && !full_o && (br_state_i != BR_WRONG);
    freed = '0;
    if (is_correct)    freed = r_oh;
    else if (is_wrong) freed = br_mask & ~br_dep_mask_i;
    dep_new  = br_mask & ~freed;
    mask_nxt = dep_new | (do_alloc ? alloc_oh : '0);
    rc_mt_sel = '0;
    rc_fl_sel = '0;
    for (int k = 0; k < BR_MASK_W; k++) begin
      if (r_oh[k]) begin
        rc_mt_sel = mt[k];
        rc_fl_sel = fl_head[k];
      end
    end
  end

  assign br_bit_o         = (br_state_i != BR_NONE) ? r_oh : '0;
  assign rc_mt_all_data_o = is_wrong ? cdb_wakeup(rc_mt_sel, cdb_vld_i, cdb_tag_i) : '0;
  assign rc_fl_head_o     = is_wrong ? rc_fl_sel : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_mask <= '0;
      for (int k = 0; k < BR_MASK_W; k++) begin
        dep_mask[k] <= '0;
        mt[k]       <= '0;
        fl_head[k]  <= '0;
      end
    end else begin
      br_mask <= mask_nxt;
      for (int k = 0; k < BR_MASK_W; k++) begin
        if (do_alloc && alloc_oh[k]) begin
          dep_mask[k] <= dep_new;
          mt[k]       <= cdb_wakeup(bak_mp_next_data_i, cdb_vld_i, cdb_tag_i);
          fl_head[k]  <= bak_fl_head_i;
        end else begin
          if (is_correct) dep_mask[k] <= dep_mask[k] & ~r_oh;
          if (br_mask[k]) mt[k] <= cdb_wakeup(mt[k], cdb_vld_i, cdb_tag_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_br_stack.sv
// Bench for br_stack: reference model feeds an expected-value queue each cycle;
// DUT outputs are popped and compared off the active edge.
module tb_br_stack;

  localparam int BMW = 5, BSW = 2, MTN = 32, PIW = 6, FLW = 5;
  localparam int MTW = MTN * (PIW + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            is_br, is_cond, is_taken, cdb_vld;
  logic [BSW-1:0]  br_state;
  logic [BMW-1:0]  br_dep;
  logic [MTW-1:0]  bak_mt;
  logic [FLW-1:0]  bak_fl;
  logic [PIW-1:0]  cdb_tag;
  logic [BMW-1:0]  br_mask_o, br_bit_o;
  logic            full_o;
  logic [MTW-1:0]  rc_mt_o;
  logic [FLW-1:0]  rc_fl_o;

  br_stack #(.BR_MASK_W(BMW), .BR_STATE_W(BSW), .MT_NUM(MTN), .PRF_IDX_W(PIW), .FL_HEAD_W(FLW)) dut (
    .clk(clk), .rst(rst), .is_br_i(is_br), .is_cond_i(is_cond), .is_taken_i(is_taken),
    .br_state_i(br_state), .br_dep_mask_i(br_dep), .bak_mp_next_data_i(bak_mt),
    .bak_fl_head_i(bak_fl), .cdb_vld_i(cdb_vld), .cdb_tag_i(cdb_tag),
    .br_mask_o(br_mask_o), .br_bit_o(br_bit_o), .full_o(full_o),
    .rc_mt_all_data_o(rc_mt_o), .rc_fl_head_o(rc_fl_o));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_q[$];

  logic [BMW-1:0] m_mask;
  logic [BMW-1:0] m_dep [BMW];
  logic [MTW-1:0] m_mt  [BMW];
  logic [FLW-1:0] m_fl  [BMW];

  logic [BMW-1:0] last_bit;
  logic [MTW-1:0] last_rc;
  logic [FLW-1:0] last_fl;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MTW-1:0] wake(input logic [MTW-1:0] d, input logic v, input logic [PIW-1:0] t);
    logic [MTW-1:0] o;
    o = d;
    for (int j = 0; j < MTN; j++)
      if (v && d[j*(PIW+1) +: PIW] == t) o[j*(PIW+1) + PIW] = 1'b1;
    return o;
  endfunction

  function automatic logic [MTW-1:0] rand_mt();
    logic [MTW-1:0] d;
    for (int j = 0; j < MTN; j++) d[j*(PIW+1) +: (PIW+1)] = 7'($urandom_range(0, 127));
    return d;
  endfunction

  function automatic logic [MTW-1:0] mt_with(input int ent, input logic [PIW-1:0] tag);
    logic [MTW-1:0] d;
    d = rand_mt();
    d[ent*(PIW+1) +: (PIW+1)] = {1'b0, tag};
    return d;
  endfunction

  task automatic cyc(input logic br, input logic [BSW-1:0] st, input logic [BMW-1:0] dep,
                     input logic cv, input logic [PIW-1:0] ct,
                     input logic [MTW-1:0] mtd, input logic [FLW-1:0] fl);
    logic       hit, ahit;
    int         r, a;
    logic [BMW-1:0] roh, freed, keep;
    @(negedge clk);
    is_br = br; br_state = st; br_dep = dep; cdb_vld = cv; cdb_tag = ct;
    bak_mt = mtd; bak_fl = fl; is_cond = br; is_taken = 1'b0;
    hit = 1'b0; r = 0;
    for (int k = 0; k < BMW; k++)
      if (!hit && m_mask[k] && m_dep[k] == dep) begin hit = 1'b1; r = k; end
    roh = hit ? (BMW'(1) << r) : '0;
    exp_q.push_back((st != 2'b00) ? 256'(roh) : 256'(0));
    exp_q.push_back((hit && st == 2'b01) ? 256'(wake(m_mt[r], cv, ct)) : 256'(0));
    exp_q.push_back((hit && st == 2'b01) ? 256'(m_fl[r]) : 256'(0));
    #1;
    last_bit = br_bit_o; last_rc = rc_mt_o; last_fl = rc_fl_o;
    check("br_bit", 256'(br_bit_o), exp_q.pop_front());
    check("rc_mt", 256'(rc_mt_o), exp_q.pop_front());
    check("rc_fl", 256'(rc_fl_o), exp_q.pop_front());
    freed = '0;
    if (hit && st == 2'b10) freed = roh;
    if (hit && st == 2'b01) freed = m_mask & ~dep;
    ahit = 1'b0; a = 0;
    if (br && m_mask != 5'h1f && st != 2'b01)
      for (int k = 0; k < BMW; k++)
        if (!ahit && !m_mask[k]) begin ahit = 1'b1; a = k; end
    keep = m_mask & ~freed;
    for (int k = 0; k < BMW; k++) begin
      if (m_mask[k]) m_mt[k] = wake(m_mt[k], cv, ct);
      if (hit && st == 2'b10) m_dep[k] = m_dep[k] & ~roh;
    end
    if (ahit) begin
      m_dep[a] = keep;
      m_mt[a]  = wake(mtd, cv, ct);
      m_fl[a]  = fl;
    end
    m_mask = keep | (ahit ? (BMW'(1) << a) : '0);
    exp_q.push_back(256'(m_mask));
    exp_q.push_back(256'(m_mask == 5'h1f));
    @(posedge clk);
    #1;
    check("br_mask", 256'(br_mask_o), exp_q.pop_front());
    check("full", 256'(full_o), exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; is_br = 1'b0; br_state = 2'b00; br_dep = '0; cdb_vld = 1'b0;
    cdb_tag = '0; bak_mt = '0; bak_fl = '0; is_cond = 1'b0; is_taken = 1'b0;
    @(posedge clk);
    #1;
    m_mask = '0;
    for (int k = 0; k < BMW; k++) begin m_dep[k] = '0; m_mt[k] = '0; m_fl[k] = '0; end
    check("rst_mask", 256'(br_mask_o), 256'(0));
    check("rst_full", 256'(full_o), 256'(0));
    check("rst_bit", 256'(br_bit_o), 256'(0));
    check("rst_rc_mt", 256'(rc_mt_o), 256'(0));
    check("rst_rc_fl", 256'(rc_fl_o), 256'(0));
    rst = 1'b0;
  endtask

  logic [BMW-1:0] seq [5];

  initial begin
    seq[0] = 5'b00001; seq[1] = 5'b00011; seq[2] = 5'b00111; seq[3] = 5'b01111; seq[4] = 5'b11111;
    rst = 1'b1;
    do_reset();

    // Fill all five slots from empty.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'b00, '0, 1'b0, '0, rand_mt(), 5'(i * 3 + 4));
      check("fill_seq", 256'(br_mask_o), 256'(seq[i]));
    end

    cyc(1'b0, 2'b10, 5'b00011, 1'b0, '0, '0, '0);
    check("corr1_bit", 256'(last_bit), 256'(5'b00100));
    cyc(1'b0, 2'b10, 5'b01011, 1'b0, '0, '0, '0);
    check("corr2_bit", 256'(last_bit), 256'(5'b10000));
    check("corr2_mask", 256'(br_mask_o), 256'(5'b01011));

    cyc(1'b0, 2'b01, 5'b00001, 1'b0, '0, '0, '0);
    check("wrong_fl", 256'(last_fl), 256'(5'd7));
    check("wrong_mask", 256'(br_mask_o), 256'(5'b00001));

    for (int i = 0; i < 4; i++) cyc(1'b1, 2'b00, '0, 1'b0, '0, rand_mt(), 5'($urandom_range(0, 31)));
    cyc(1'b1, 2'b00, '0, 1'b0, '0, rand_mt(), 5'd9);
    check("full_ignore", 256'(br_mask_o), 256'(5'b11111));

    cyc(1'b0, 2'b10, 5'b10101, 1'b0, '0, '0, '0);
    check("nomatch_bit", 256'(last_bit), 256'(0));

    // Mispredict with a simultaneous dispatch: the dispatch must not land.
    cyc(1'b1, 2'b01, 5'b00001, 1'b0, '0, rand_mt(), 5'd3);
    check("wrong_drop", 256'(br_mask_o), 256'(5'b00001));

    // CDB wakes a stored checkpoint entry, recovered afterwards.
    cyc(1'b1, 2'b00, '0, 1'b0, '0, mt_with(0, 6'd17), 5'd21);
    cyc(1'b0, 2'b00, '0, 1'b1, 6'd17, '0, '0);
    cyc(1'b0, 2'b01, 5'b00001, 1'b0, '0, '0, '0);
    check("cdb_stored", 256'(last_rc[6]), 256'(1));

    // CDB forwarded straight into the recovery output.
    cyc(1'b1, 2'b00, '0, 1'b0, '0, mt_with(3, 6'd9), 5'd22);
    cyc(1'b0, 2'b01, 5'b00001, 1'b1, 6'd9, '0, '0);
    check("cdb_fwd", 256'(last_rc[27]), 256'(1));

    // CDB on the capture cycle itself.
    cyc(1'b1, 2'b00, '0, 1'b1, 6'd40, mt_with(5, 6'd40), 5'd23);
    cyc(1'b0, 2'b01, 5'b00001, 1'b0, '0, '0, '0);
    check("cdb_capture", 256'(last_rc[41]), 256'(1));

    for (int i = 0; i < 6; i++)
      cyc(1'b1, 2'b00, '0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), rand_mt(), 5'(i));
    do_reset();
    cyc(1'b1, 2'b00, '0, 1'b0, '0, rand_mt(), 5'd1);
    check("post_rst", 256'(br_mask_o), 256'(5'b00001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
